// File: rtl/bus_arbiter_if.sv
// Request/response bundle between two bus masters, the arbiter and the shared memory/IO bus.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_ready;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_ready;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_we;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic [1:0]            bus_owner;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_ready, m0_rvalid, m0_rdata,
        output m1_ready, m1_rvalid, m1_rdata,
        output bus_addr, bus_we, bus_wdata, bus_owner
    );

    // Masters plus the memory/IO bus
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_ready, m0_rvalid, m0_rdata,
        input  m1_ready, m1_rvalid, m1_rdata,
        input  bus_addr, bus_we, bus_wdata, bus_owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with burst cap; ready is combinational from the owner's req,
// read data returns one cycle after accept; a non-owner sees ready low until handed the bus.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bif
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    state_t          oth_state;
    logic            last_grant;
    logic [CW-1:0]   burst_cnt;
    logic            rd_pend0;
    logic            rd_pend1;

    logic            own0;
    logic            own1;
    logic            acc0;
    logic            acc1;
    logic            cur_req;
    logic            oth_req;
    logic            cap_hit;

    assign own0      = (state == OWN0);
    assign own1      = (state == OWN1);
    assign acc0      = own0 & bif.m0_req;
    assign acc1      = own1 & bif.m1_req;
    assign cur_req   = own0 ? bif.m0_req : bif.m1_req;
    assign oth_req   = own0 ? bif.m1_req : bif.m0_req;
    assign oth_state = own0 ? OWN1 : OWN0;
    // ">=" so an owner whose count saturated during a lone run yields on its next accept
    assign cap_hit   = (burst_cnt >= CW'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bif.m0_req && (!bif.m1_req || last_grant)) state_nxt = OWN0;
                else if (bif.m1_req)                          state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!cur_req)               state_nxt = oth_req ? oth_state : IDLE;
                else if (oth_req && cap_hit) state_nxt = oth_state;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            rd_pend0   <= 1'b0;
            rd_pend1   <= 1'b0;
        end else begin
            rd_pend0 <= acc0 & ~bif.m0_we;
            rd_pend1 <= acc1 & ~bif.m1_we;
            if (state_nxt != state) begin
                state     <= state_nxt;
                burst_cnt <= '0;
                if (state_nxt != IDLE) last_grant <= (state_nxt == OWN1);
            end else if ((acc0 | acc1) && burst_cnt != CW'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end
    end

    // Everything is forced low while reset is held, including a read that was already in flight
    assign bif.m0_ready  = ~reset & acc0;
    assign bif.m1_ready  = ~reset & acc1;
    assign bif.m0_rvalid = ~reset & rd_pend0;
    assign bif.m1_rvalid = ~reset & rd_pend1;
    assign bif.m0_rdata  = (~reset & rd_pend0) ? bif.bus_rdata : '0;
    assign bif.m1_rdata  = (~reset & rd_pend1) ? bif.bus_rdata : '0;

    assign bif.bus_addr  = reset ? '0 : own0 ? bif.m0_addr  : own1 ? bif.m1_addr  : '0;
    assign bif.bus_we    = reset ? 1'b0 : own0 ? bif.m0_we : own1 ? bif.m1_we     : 1'b0;
    assign bif.bus_wdata = reset ? '0 : own0 ? bif.m0_wdata : own1 ? bif.m1_wdata : '0;
    assign bif.bus_owner = reset ? 2'b00 : {own1, own0};
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, all checked against a cycle-level model.
module tb_bus_arbiter;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          MB   = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    // Master drivers
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    txn_t q0[$];
    txn_t q1[$];
    int   gap [2];

    assign bif.m0_req   = req[0];
    assign bif.m0_we    = we[0];
    assign bif.m0_addr  = addr[0];
    assign bif.m0_wdata = wdata[0];
    assign bif.m1_req   = req[1];
    assign bif.m1_we    = we[1];
    assign bif.m1_addr  = addr[1];
    assign bif.m1_wdata = wdata[1];

    // Memory on the bus: registered read of the presented address
    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 1) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    logic          mem_init;
    logic [15:0]   written;
    logic [DW-1:0] mem [16];
    logic [3:0]    bidx;
    assign bidx = bif.bus_addr[5:2];

    always_ff @(posedge clk) begin
        if (mem_init) begin
            written <= '0;
        end else if (bif.bus_we) begin
            mem[bidx]     <= bif.bus_wdata;
            written[bidx] <= 1'b1;
        end
        bif.bus_rdata <= (!mem_init && written[bidx]) ? mem[bidx] : init_word(int'(bidx));
    end

    // Reference model: owner (0 none, 1 m0, 2 m1), last owner, accepts in current tenure
    int          own, last, tenure;
    bit          pend [2];
    logic [31:0] pdat [2];
    logic [31:0] mm   [16];

    int          s_rdy [2];
    int          s_rv  [2];
    int          s_owner;
    logic [31:0] cap_rd [2];
    int          rv_cnt [2];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
        return '{we: w, addr: a, wdata: d};
    endfunction

    function automatic txn_t rand_txn();
        logic w;
        w = 1'($urandom_range(1));
        return mk(w, BASE + 32'(4 * $urandom_range(15)), w ? $urandom : 32'h0);
    endfunction

    task automatic drive(input int d0, input int d1);
        int   done [2];
        txn_t t;
        bit   ld;
        done[0] = d0;
        done[1] = d1;
        for (int m = 0; m < 2; m++) begin
            if (req[m] && done[m] != 0) begin
                req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
            end
            ld = 1'b0;
            if (!req[m] && $urandom_range(99) >= gap[m]) begin
                if (m == 0 && q0.size() > 0) begin t = q0.pop_front(); ld = 1'b1; end
                if (m == 1 && q1.size() > 0) begin t = q1.pop_front(); ld = 1'b1; end
            end
            if (ld) begin
                req[m] = 1'b1; we[m] = t.we; addr[m] = t.addr; wdata[m] = t.wdata;
            end
        end
    endtask

    task automatic step();
        bit acc [2];
        int n_own, me, ot;
        @(negedge clk);
        s_rdy[0] = int'(bif.m0_ready);
        s_rdy[1] = int'(bif.m1_ready);
        s_rv[0]  = int'(bif.m0_rvalid);
        s_rv[1]  = int'(bif.m1_rvalid);
        s_owner  = int'(bif.bus_owner);
        if (reset) begin
            check_val("rst_ready0",  32'(s_rdy[0]), 0);
            check_val("rst_ready1",  32'(s_rdy[1]), 0);
            check_val("rst_rvalid0", 32'(s_rv[0]), 0);
            check_val("rst_rvalid1", 32'(s_rv[1]), 0);
            check_val("rst_bus_we",  32'(bif.bus_we), 0);
            check_val("rst_bus_addr", bif.bus_addr, 0);
            check_val("rst_bus_wdata", bif.bus_wdata, 0);
            check_val("rst_owner",   32'(s_owner), 0);
            own = 0; last = 2; tenure = 0;
            pend[0] = 1'b0; pend[1] = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) acc[m] = (own == m + 1) && req[m];
            check_val("ready0",  32'(s_rdy[0]), 32'(acc[0]));
            check_val("ready1",  32'(s_rdy[1]), 32'(acc[1]));
            check_val("rvalid0", 32'(s_rv[0]), 32'(pend[0]));
            check_val("rvalid1", 32'(s_rv[1]), 32'(pend[1]));
            check_val("rdata0",  bif.m0_rdata, pend[0] ? pdat[0] : 32'h0);
            check_val("rdata1",  bif.m1_rdata, pend[1] ? pdat[1] : 32'h0);
            check_val("owner",   32'(s_owner), 32'(own));
            if (own == 0) begin
                check_val("idle_addr", bif.bus_addr, 0);
                check_val("idle_we",   32'(bif.bus_we), 0);
            end else begin
                check_val("bus_addr",  bif.bus_addr, addr[own-1]);
                check_val("bus_we",    32'(bif.bus_we), 32'(we[own-1]));
                check_val("bus_wdata", bif.bus_wdata, wdata[own-1]);
            end
            for (int m = 0; m < 2; m++) begin
                pend[m] = acc[m] && !we[m];
                if (pend[m]) pdat[m] = mm[addr[m][5:2]];
                if (acc[m] && we[m]) mm[addr[m][5:2]] = wdata[m];
            end
            n_own = own;
            if (own == 0) begin
                if (req[0] && req[1]) n_own = (last == 1) ? 2 : 1;
                else if (req[0])      n_own = 1;
                else if (req[1])      n_own = 2;
            end else begin
                me = own - 1;
                ot = 2 - own;
                if (!req[me])                          n_own = req[ot] ? ot + 1 : 0;
                else if (req[ot] && tenure + 1 >= MB)  n_own = ot + 1;
            end
            if (n_own != own) begin
                tenure = 0;
                if (n_own != 0) last = n_own;
            end else if (acc[0] || acc[1]) begin
                tenure++;
            end
            own = n_own;
        end
        if (s_rv[0] != 0) begin rv_cnt[0]++; cap_rd[0] = bif.m0_rdata; end
        if (s_rv[1] != 0) begin rv_cnt[1]++; cap_rd[1] = bif.m1_rdata; end
        @(posedge clk);
        #1;
        drive(s_rdy[0], s_rdy[1]);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((req[0] || req[1] || q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1]) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_busy", 32'(int'(req[0] || req[1] || q0.size() > 0 || q1.size() > 0)), 0);
    endtask

    initial begin
        int n, acc_n, first, last_c, c;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
            gap[m] = 0; rv_cnt[m] = 0; pend[m] = 1'b0; cap_rd[m] = '0; pdat[m] = '0;
        end
        for (int i = 0; i < 16; i++) mm[i] = init_word(i);
        own = 0; last = 2; tenure = 0;
        mem_init = 1'b1;

        // Reset held two cycles with both masters requesting
        q0.push_back(mk(1'b0, BASE + 32'h8, 32'h0));
        q1.push_back(mk(1'b0, BASE + 32'hC, 32'h0));
        drive(0, 0);
        step();
        mem_init = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_val("rel_c1_owner", 32'(s_owner), 0);
        check_val("rel_c1_ready0", 32'(s_rdy[0]), 0);
        step();
        check_val("rel_c2_ready0", 32'(s_rdy[0]), 1);
        check_val("rel_c2_owner", 32'(s_owner), 1);
        run_idle(50);

        // Single read of a preloaded RAM word
        q0.push_back(mk(1'b0, BASE + 32'h4, 32'h0));
        run_idle(20);
        check_val("single_rd_data", cap_rd[0], 32'hDEAD_BEEF);

        // m0 writes then drops; m1 reads the same word
        q0.push_back(mk(1'b1, BASE, 32'h1234_5678));
        drive(0, 0);
        step();
        q1.push_back(mk(1'b0, BASE, 32'h0));
        drive(0, 0);
        step();
        check_val("ho_wr_accept", 32'(s_rdy[0]), 1);
        step();
        check_val("ho_drop_owner", 32'(s_owner), 1);
        step();
        check_val("ho_owner1", 32'(s_owner), 2);
        check_val("ho_ready1", 32'(s_rdy[1]), 1);
        run_idle(20);
        check_val("ho_rd_data", cap_rd[1], 32'h1234_5678);

        // Fairness: both request continuously
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (12) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        drive(0, 0);
        n = 0; acc_n = 0; first = 0; last_c = 0;
        while (acc_n < 24 && n < 200) begin
            step();
            n++;
            if (s_rdy[0] != 0 || s_rdy[1] != 0) begin
                check_val("fair_order", 32'(s_rdy[1]), 32'((acc_n / MB) % 2));
                if (acc_n == 0) first = n;
                acc_n++;
                last_c = n;
            end
        end
        check_val("fair_count", 32'(acc_n), 24);
        check_val("fair_span", 32'(last_c - first + 1), 24);
        run_idle(20);

        // Lone master keeps the bus for a long read run
        c = rv_cnt[1];
        repeat (10) q1.push_back(mk(1'b0, BASE + 32'(4 * $urandom_range(15)), 32'h0));
        drive(0, 0);
        run_idle(60);
        check_val("lone_rvalids", 32'(rv_cnt[1] - c), 10);

        // Reset lands on the cycle the read data would return
        q0.push_back(mk(1'b0, BASE + 32'h4, 32'h0));
        drive(0, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (s_rdy[0] == 0 && n < 10);
        check_val("mid_accept", 32'(s_rdy[0]), 1);
        reset = 1'b1;
        step();
        check_val("mid_rvalid", 32'(s_rv[0]), 0);
        reset = 1'b0;
        q0.push_back(mk(1'b0, BASE + 32'h8, 32'h0));
        drive(0, 0);
        step();
        check_val("mid_idle", 32'(s_owner), 0);
        step();
        check_val("mid_regrant", 32'(s_rdy[0]), 1);
        run_idle(20);

        // Random traffic with idle gaps and occasional resets
        gap[0] = 30;
        gap[1] = 50;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 40 && q0.size() < 4) q0.push_back(rand_txn());
            if ($urandom_range(99) < 60 && q1.size() < 4) q1.push_back(rand_txn());
            reset = ($urandom_range(999) < 3);
            step();
        end
        reset = 1'b0;
        run_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
